inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch unit: owns the PC, issues in-order word requests to instruction memory, buffers returned instructions in a small prefetch FIFO, and presents one instruction per cycle with its address to the IF/ID pipeline register. It honours the same stall signal as the IF/ID register and redirects on jump/branch flushes, discarding responses still in flight from the old path.

## Interface
- DEPTH, 2: prefetch FIFO entries; also the credit limit for occupancy plus in-flight requests. Power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- jump_flag_i  in  1  redirect request from execute
- jump_addr_i  in  32  redirect target; bits [1:0] ignored (forced 0)
- stall_i  in  1  downstream hold; same signal that holds IF/ID
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  32  fetch address (current PC)
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response valid; in order, ≥1 cycle after grant
- imem_rdata_i  in  32  response instruction word
- inst_o  out  32  instruction to IF/ID; `INST_NOP when invalid
- inst_addr_o  out  32  address of inst_o; `ZeroWord when invalid
- inst_valid_o  out  1  FIFO head valid

## Operation
- State: pc, FIFO (inst, addr pairs), in-flight address queue (DEPTH deep), inflight count, drop count.
- pop = inst_valid_o & !stall_i & !jump_flag_i.
- imem_req_o = rst & !jump_flag_i & (occupancy + inflight − pop < DEPTH).
- Grant (req & gnt): pc += 4 (wraps mod 2^32); address pushed to in-flight queue; inflight++.
- Response with drop count > 0: word discarded, drop−−, inflight−−.
- Response with drop = 0: (rdata, in-flight head address) pushed to FIFO; inflight−−.
- Output: FIFO head drives inst_o / inst_addr_o; empty FIFO drives `INST_NOP / `ZeroWord with inst_valid_o = 0 (bubble).
- Stall: head held, no pop; fetching continues until credits are exhausted.
- Jump (priority over stall and pop): pc ← {jump_addr_i[31:2],2'b00}; FIFO cleared; drop ← inflight − (response accepted this cycle ? 1 : 0); any response in the jump cycle is discarded; no request issued in the jump cycle.
- Credit rule guarantees no FIFO overflow; push and pop in the same cycle are legal at any occupancy.
- Reset (async, any time): pc = RESET_PC, FIFO and queues empty, inflight = drop = 0. Outputs: imem_req_o 0, imem_addr_o RESET_PC, inst_o `INST_NOP, inst_addr_o `ZeroWord, inst_valid_o 0.

## Timing
- Request-to-output latency: response cycle + 1 (FIFO registered, no bypass).
- Zero-wait memory (gnt = 1, rvalid one cycle later), DEPTH = 2: first request in cycle 0 after reset release, data in cycle 1, inst_o valid in cycle 2, one instruction per cycle thereafter.
- imem_req_o depends combinationally on stall_i and jump_flag_i; imem_addr_o and all inst_* outputs are registered.
- Jump in cycle J: first new-path request in J+1; first new-path instruction at output no earlier than J+3; inst_valid_o = 0 from J+1 until then.

## Structure
- Shared defines.v: `InstBus, `InstAddrBus, `INST_NOP, `ZeroWord; add `PcStep (4).
- Sub-module fetch_fifo: synchronous FIFO, parameterised width and depth, with push, pop, clear, count. Instantiated twice: 64-bit data FIFO and 32-bit in-flight address queue.

## Test plan
- Reset, zero-wait memory returning addr as data: inst_addr_o 0x0, 0x4, 0x8 in consecutive cycles from cycle 2; no bubbles.
- stall_i high 3 cycles while streaming: inst_o/inst_addr_o held constant; at most DEPTH outstanding; resumes with the next sequential address and no loss or duplication.
- imem_gnt_i low 4 cycles: imem_addr_o stable while imem_req_o high; output goes invalid (`INST_NOP) once drained; resumes in order.
- Jump to 0x100 with two responses in flight (rvalid delayed 2 cycles): both stale words dropped; next valid inst_addr_o is 0x100, then 0x104.
- Jump with jump_addr_i = 0x203 and stall_i high in the same cycle: fetch resumes at 0x200; FIFO flushed despite the stall.
- Assert rst mid-stream with a response pending: outputs return to reset values immediately; after release, fetch restarts at RESET_PC and the late response is not delivered.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package inst_fetch_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] inst_t;       // instruction bus
  typedef logic [XLEN-1:0] inst_addr_t;  // instruction address bus

  // Bubble values presented when no instruction is available.
  localparam inst_t      INST_NOP  = 32'h0000_0001;
  localparam inst_addr_t ZERO_WORD = 32'h0000_0000;

  // Sequential fetch increment (one 32-bit word).
  localparam inst_addr_t PC_STEP = 32'd4;

  // One prefetch FIFO entry: instruction word plus the address it came from.
  typedef struct packed {
    inst_t      inst;
    inst_addr_t addr;
  } fetch_entry_t;

  // Redirect targets are always word aligned; the low two bits are dropped.
  function automatic inst_addr_t align_word(input inst_addr_t a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Synchronous FIFO with push, pop, clear and occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; clear wins over push and pop.
module inst_fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Next-state for pointers and occupancy; pointers wrap naturally (DEPTH is a power of two).
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, issues in-order word requests under a
// credit limit of DEPTH (FIFO occupancy plus in-flight requests), buffers
// responses in a prefetch FIFO and hands one instruction per cycle to IF/ID.
// A jump flushes the FIFO and marks every in-flight response for discard.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned UW = CW + 1;

  inst_addr_t   pc_q, pc_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] occ, infl;
  logic [UW-1:0] used_slots;
  logic          pop, grant, resp_keep;
  fetch_entry_t  push_entry, head_entry;
  inst_addr_t    aq_head;

  // Credit check, request, grant and response steering.
  always_comb begin
    pop        = inst_valid_o && !stall_i && !jump_flag_i;
    used_slots = UW'(occ) + UW'(infl) - UW'(pop);
    imem_req_o = rst && !jump_flag_i && (used_slots < UW'(DEPTH));
    grant      = imem_req_o && imem_gnt_i;
    resp_keep  = imem_rvalid_i && !jump_flag_i && (drop_q == '0);
    push_entry.inst = imem_rdata_i;
    push_entry.addr = aq_head;
  end

  // Next PC and count of stale responses still to be discarded.
  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (jump_flag_i) begin
      pc_d   = align_word(jump_addr_i);
      drop_d = infl - CW'(imem_rvalid_i);
    end else begin
      if (grant) pc_d = pc_q + PC_STEP;
      if (imem_rvalid_i && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  // PC and drop counter registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  // Prefetch FIFO of (instruction, address) pairs; flushed on a jump.
  inst_fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_data_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .clear_i (jump_flag_i),
    .push_i  (resp_keep),
    .pop_i   (pop),
    .data_i  (push_entry),
    .data_o  (head_entry),
    .count_o (occ)
  );

  // In-flight address queue; never flushed because stale responses still
  // arrive and must retire their entries in order.
  inst_fetch_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_addr_queue (
    .clk     (clk),
    .rst_n   (rst),
    .clear_i (1'b0),
    .push_i  (grant),
    .pop_i   (imem_rvalid_i),
    .data_i  (pc_q),
    .data_o  (aq_head),
    .count_o (infl)
  );

  // Output presentation: FIFO head, or a bubble when empty.
  always_comb begin
    inst_valid_o = (occ != '0);
    inst_o       = inst_valid_o ? head_entry.inst : INST_NOP;
    inst_addr_o  = inst_valid_o ? head_entry.addr : ZERO_WORD;
  end

  assign imem_addr_o = pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a queue-based memory responder and a
// reference model built from the fetch rules, with directed scenarios and a
// randomized run.
module tb_inst_fetch;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0001;
  localparam logic [31:0] ZERO     = 32'h0000_0000;
  localparam logic [31:0] DATA_XOR = 32'hDEAD_0000;

  logic        clk;
  logic        rst;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        stall_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  inst_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .jump_flag_i   (jump_flag_i),
    .jump_addr_i   (jump_addr_i),
    .stall_i       (stall_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .inst_o        (inst_o),
    .inst_addr_o   (inst_addr_o),
    .inst_valid_o  (inst_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  int cyc;

  // Reference model: PC, buffered (inst, addr) pairs, in-flight requests tagged by path epoch.
  logic [31:0] m_pc;
  logic [31:0] mf_inst[$];
  logic [31:0] mf_addr[$];
  logic [31:0] mi_addr[$];
  int          mi_ep[$];
  int          epoch;
  bit          m_pop;

  // Memory responder: pending responses with due cycles.
  logic [31:0] mem_addr[$];
  int          mem_due[$];
  int          last_due;
  int          lat;
  bit          gnt_on;

  logic [97:0] exp_vec;
  logic [97:0] reset_vec;

  function automatic logic [97:0] act();
    return {inst_valid_o, inst_o, inst_addr_o, imem_req_o, imem_addr_o};
  endfunction

  task automatic clear_env();
    mf_inst.delete(); mf_addr.delete(); mi_addr.delete(); mi_ep.delete();
    mem_addr.delete(); mem_due.delete();
    m_pc = RESET_PC; epoch = 0; last_due = cyc;
    stall_i = 0; jump_flag_i = 0; jump_addr_i = 0; imem_gnt_i = 0;
    imem_rvalid_i = 0; imem_rdata_i = 0;
  endtask

  // Apply inputs for this cycle and compute the expected outputs.
  task automatic drive(input bit s, input bit j, input logic [31:0] ja);
    logic        ev;
    logic        er;
    logic [31:0] ei, ea;
    stall_i = s; jump_flag_i = j; jump_addr_i = ja; imem_gnt_i = gnt_on;
    if (mem_due.size() > 0 && mem_due[0] <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_addr[0] ^ DATA_XOR;
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    #1;
    ev = (mf_inst.size() != 0);
    ei = ev ? mf_inst[0] : NOP;
    ea = ev ? mf_addr[0] : ZERO;
    m_pop = ev && !s && !j;
    er = !j && ((mf_inst.size() + mi_addr.size() - int'(m_pop)) < DEPTH);
    exp_vec = {ev, ei, ea, er, m_pc};
  endtask

  // Advance the model and the memory by one clock.
  task automatic tick();
    bit          rv;
    bit          mgrant;
    logic [31:0] rd, a;
    int          e, due;
    rv = imem_rvalid_i;
    rd = imem_rdata_i;
    mgrant = exp_vec[32] && imem_gnt_i;
    if (jump_flag_i) begin
      m_pc = {jump_addr_i[31:2], 2'b00};
      mf_inst.delete(); mf_addr.delete();
      epoch++;
      if (rv && mi_addr.size() > 0) begin
        void'(mi_addr.pop_front()); void'(mi_ep.pop_front());
      end
    end else begin
      if (m_pop) begin
        void'(mf_inst.pop_front()); void'(mf_addr.pop_front());
      end
      if (rv && mi_addr.size() > 0) begin
        a = mi_addr.pop_front();
        e = mi_ep.pop_front();
        if (e == epoch) begin
          mf_inst.push_back(rd); mf_addr.push_back(a);
        end
      end
    end
    if (mgrant) begin
      mi_addr.push_back(m_pc); mi_ep.push_back(epoch);
      m_pc = m_pc + 32'd4;
    end
    if (rv) begin
      void'(mem_addr.pop_front()); void'(mem_due.pop_front());
    end
    if (imem_req_o && imem_gnt_i) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      mem_addr.push_back(imem_addr_o); mem_due.push_back(due);
      last_due = due;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_env();
    gnt_on = 1'b1; lat = 1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (act() !== reset_vec) begin
        miscompares++;
        $display("FAIL reset_state cyc=%0d got=%h exp=%h", i, act(), reset_vec);
      end
      @(negedge clk);
    end
    rst = 1'b1;
  endtask

  task automatic test_stream();
    gnt_on = 1'b1; lat = 1;
    for (int c = 0; c < 8; c++) begin
      drive(0, 0, 0);
      vectors++;
      if (act() !== exp_vec) begin
        miscompares++;
        $display("FAIL stream cyc=%0d got=%h exp=%h", c, act(), exp_vec);
      end
      if (c >= 2) begin
        vectors++;
        if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'((c - 2) * 4)) begin
          miscompares++;
          $display("FAIL stream_addr cyc=%0d got=%b/%h exp=1/%h", c, inst_valid_o, inst_addr_o, 32'((c - 2) * 4));
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [63:0] held;
    gnt_on = 1'b1; lat = 1;
    held = '0;
    for (int c = 0; c < 9; c++) begin
      drive(c >= 2 && c < 5, 0, 0);
      vectors++;
      if (act() !== exp_vec) begin
        miscompares++;
        $display("FAIL stall cyc=%0d got=%h exp=%h", c, act(), exp_vec);
      end
      if (c == 2) held = {inst_o, inst_addr_o};
      if (c >= 2 && c <= 5) begin
        vectors++;
        if (inst_valid_o !== 1'b1 || {inst_o, inst_addr_o} !== held) begin
          miscompares++;
          $display("FAIL stall_hold cyc=%0d got=%h exp=%h", c, {inst_o, inst_addr_o}, held);
        end
      end
      if (c == 6) begin
        vectors++;
        if (inst_valid_o !== 1'b1 || inst_addr_o !== held[31:0] + 32'd4) begin
          miscompares++;
          $display("FAIL stall_resume got=%b/%h exp=1/%h", inst_valid_o, inst_addr_o, held[31:0] + 32'd4);
        end
      end
      tick();
    end
  endtask

  task automatic test_gnt_low();
    logic [31:0] cap;
    bit          found;
    lat = 1; cap = '0; found = 0;
    for (int c = 0; c < 16; c++) begin
      gnt_on = !(c >= 2 && c < 6);
      drive(0, 0, 0);
      vectors++;
      if (act() !== exp_vec) begin
        miscompares++;
        $display("FAIL gnt_low cyc=%0d got=%h exp=%h", c, act(), exp_vec);
      end
      if (c == 2) cap = imem_addr_o;
      if (c >= 2 && c < 6) begin
        vectors++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== cap) begin
          miscompares++;
          $display("FAIL gnt_low_addr cyc=%0d got=%b/%h exp=1/%h", c, imem_req_o, imem_addr_o, cap);
        end
      end
      if (c == 5) begin
        vectors++;
        if (inst_valid_o !== 1'b0 || inst_o !== NOP || inst_addr_o !== ZERO) begin
          miscompares++;
          $display("FAIL gnt_low_bubble got=%b/%h/%h exp=0/%h/%h", inst_valid_o, inst_o, inst_addr_o, NOP, ZERO);
        end
      end
      if (c >= 6 && !found && inst_valid_o === 1'b1) begin
        found = 1;
        vectors++;
        if (inst_addr_o !== cap) begin
          miscompares++;
          $display("FAIL gnt_low_resume got=%h exp=%h", inst_addr_o, cap);
        end
      end
      tick();
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL gnt_low_resume got=no_valid exp=%h", cap);
    end
  endtask

  task automatic test_jump_inflight();
    int n;
    int k_first;
    gnt_on = 1'b1; lat = 2;
    n = 0;
    while (mi_addr.size() != 2 && n < 20) begin
      drive(0, 0, 0);
      vectors++;
      if (act() !== exp_vec) begin
        miscompares++;
        $display("FAIL jump_pre cyc=%0d got=%h exp=%h", n, act(), exp_vec);
      end
      tick();
      n++;
    end
    vectors++;
    if (mi_addr.size() != 2) begin
      miscompares++;
      $display("FAIL jump_setup got=%0d in_flight exp=2", mi_addr.size());
    end
    drive(0, 1, 32'h0000_0100);
    vectors++;
    if (act() !== exp_vec) begin
      miscompares++;
      $display("FAIL jump_cycle got=%h exp=%h", act(), exp_vec);
    end
    tick();
    k_first = -1;
    for (int k = 0; k < 14; k++) begin
      drive(0, 0, 0);
      vectors++;
      if (act() !== exp_vec) begin
        miscompares++;
        $display("FAIL jump_post k=%0d got=%h exp=%h", k, act(), exp_vec);
      end
      if (k == 0) begin
        vectors++;
        if (imem_addr_o !== 32'h100 || inst_valid_o !== 1'b0) begin
          miscompares++;
          $display("FAIL jump_redirect got=%h/%b exp=00000100/0", imem_addr_o, inst_valid_o);
        end
      end
      if (k_first >= 0 && k == k_first + 1) begin
        vectors++;
        if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h104) begin
          miscompares++;
          $display("FAIL jump_second got=%b/%h exp=1/00000104", inst_valid_o, inst_addr_o);
        end
      end
      if (k_first < 0 && inst_valid_o === 1'b1) begin
        k_first = k;
        vectors++;
        if (k < 1 || inst_addr_o !== 32'h100) begin
          miscompares++;
          $display("FAIL jump_first k=%0d got=%h exp=00000100", k, inst_addr_o);
        end
      end
      tick();
    end
    vectors++;
    if (k_first < 0) begin
      miscompares++;
      $display("FAIL jump_first got=no_valid exp=00000100");
    end
  endtask

  task automatic test_jump_stall();
    int k_first;
    gnt_on = 1'b1; lat = 1;
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 0);
      vectors++;
      if (act() !== exp_vec) begin
        miscompares++;
        $display("FAIL jstall_pre cyc=%0d got=%h exp=%h", c, act(), exp_vec);
      end
      tick();
    end
    drive(1, 1, 32'h0000_0203);
    vectors++;
    if (act() !== exp_vec) begin
      miscompares++;
      $display("FAIL jstall_cycle got=%h exp=%h", act(), exp_vec);
    end
    tick();
    k_first = -1;
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 0);
      vectors++;
      if (act() !== exp_vec) begin
        miscompares++;
        $display("FAIL jstall_post k=%0d got=%h exp=%h", k, act(), exp_vec);
      end
      if (k == 0) begin
        vectors++;
        if (inst_valid_o !== 1'b0 || imem_addr_o !== 32'h200) begin
          miscompares++;
          $display("FAIL jstall_flush got=%b/%h exp=0/00000200", inst_valid_o, imem_addr_o);
        end
      end
      if (k_first >= 0 && k == k_first + 1) begin
        vectors++;
        if (inst_addr_o !== 32'h204) begin
          miscompares++;
          $display("FAIL jstall_second got=%h exp=00000204", inst_addr_o);
        end
      end
      if (k_first < 0 && inst_valid_o === 1'b1) begin
        k_first = k;
        vectors++;
        if (inst_addr_o !== 32'h200) begin
          miscompares++;
          $display("FAIL jstall_first got=%h exp=00000200", inst_addr_o);
        end
      end
      tick();
    end
    vectors++;
    if (k_first < 0) begin
      miscompares++;
      $display("FAIL jstall_first got=no_valid exp=00000200");
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    gnt_on = 1'b1; lat = 3;
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 0);
      vectors++;
      if (act() !== exp_vec) begin
        miscompares++;
        $display("FAIL rmid_pre cyc=%0d got=%h exp=%h", c, act(), exp_vec);
      end
      tick();
    end
    vectors++;
    if (mem_addr.size() == 0) begin
      miscompares++;
      $display("FAIL rmid_setup got=0 pending exp=nonzero");
    end
    drive(0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if (act() !== reset_vec) begin
      miscompares++;
      $display("FAIL rmid_async got=%h exp=%h", act(), reset_vec);
    end
    @(negedge clk);
    cyc++;
    clear_env();
    @(negedge clk);
    cyc++;
    rst = 1'b1;
    lat = 1;
    found = 0;
    for (int c = 0; c < 6; c++) begin
      drive(0, 0, 0);
      vectors++;
      if (act() !== exp_vec) begin
        miscompares++;
        $display("FAIL rmid_post cyc=%0d got=%h exp=%h", c, act(), exp_vec);
      end
      if (!found && inst_valid_o === 1'b1) begin
        found = 1;
        vectors++;
        if (c != 2 || inst_addr_o !== RESET_PC) begin
          miscompares++;
          $display("FAIL rmid_restart cyc=%0d got=%h exp=%h at cyc 2", c, inst_addr_o, RESET_PC);
        end
      end
      tick();
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL rmid_restart got=no_valid exp=%h", RESET_PC);
    end
  endtask

  task automatic test_random();
    bit          s, j;
    logic [31:0] ja;
    for (int c = 0; c < 400; c++) begin
      gnt_on = ($urandom_range(0, 3) != 0);
      lat    = $urandom_range(1, 3);
      s      = ($urandom_range(0, 3) == 0);
      j      = ($urandom_range(0, 19) == 0);
      ja     = $urandom;
      drive(s, j, ja);
      vectors++;
      if (act() !== exp_vec) begin
        miscompares++;
        $display("FAIL random cyc=%0d got=%h exp=%h", c, act(), exp_vec);
      end
      tick();
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    gnt_on = 1'b1; lat = 1;
    reset_vec = {1'b0, NOP, ZERO, 1'b0, RESET_PC};
    rst = 1'b0;
    clear_env();
    test_reset();
    test_stream();
    test_stall();
    test_gnt_low();
    test_jump_inflight();
    test_jump_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
